// File: rtl/mem_defs.sv
// Shared encodings for the multi-cycle MEM stage: memrw codes, FSM states, default bank split.
// Pure definitions; no timing or flow control of its own.
package mem_defs;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } memrw_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  localparam logic [15:0] BANK_SPLIT_DEF = 16'h8000;
  localparam int          CNT_W          = 4;

  function automatic logic is_mem_op(input logic [1:0] rw);
    return (rw == MEM_LOAD) || (rw == MEM_STORE);
  endfunction

endpackage

// File: rtl/sram_port.sv
// Strobe/address/data driver for one SRAM bank; purely combinational from the controller's phase.
// Bank is idle (strobes high, bus released, addr/data zero) whenever it is not selected.
module sram_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              sel_i,
  input  logic              is_store_i,
  input  logic              last_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              ce_o,
  output logic              re_o,
  output logic              we_o,
  output logic              oe_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    ce_o   = 1'b1;
    re_o   = 1'b1;
    we_o   = 1'b1;
    oe_o   = 1'b0;
    addr_o = '0;
    data_o = '0;
    if (sel_i) begin
      ce_o   = 1'b0;
      addr_o = addr_i;
      if (is_store_i) begin
        oe_o   = 1'b1;
        data_o = wr_data_i;
        // we rises on the last access cycle so data is held past the write edge
        we_o   = last_i;
      end else begin
        re_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle MEM stage: routes loads/stores to ram1/ram2 by address with WAIT_CYCLES access cycles.
// Non-memory ops pass through with zero latency; memory ops hold stall_req for WAIT_CYCLES+1 cycles.
module mem_ctrl
  import mem_defs::*;
#(
  parameter int              DATA_W      = 16,
  parameter int              ADDR_W      = 16,
  parameter int              REG_W       = 4,
  parameter int              WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BANK_SPLIT = ADDR_W'(BANK_SPLIT_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] memdata_i,
  input  logic [1:0]        memrw_i,
  input  logic [ADDR_W-1:0] memaddr_i,
  output logic              we_o,
  output logic [REG_W-1:0]  waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] ram1_data_i,
  output logic [DATA_W-1:0] ram1_data_o,
  output logic              ram1_oe_o,
  output logic [ADDR_W-1:0] ram1_addr_o,
  output logic              ram1_ce_o,
  output logic              ram1_re_o,
  output logic              ram1_we_o,
  input  logic [DATA_W-1:0] ram2_data_i,
  output logic [DATA_W-1:0] ram2_data_o,
  output logic              ram2_oe_o,
  output logic [ADDR_W-1:0] ram2_addr_o,
  output logic              ram2_ce_o,
  output logic              ram2_re_o,
  output logic              ram2_we_o,
  output logic              stall_req,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [REG_W-1:0]    waddr_q, waddr_d;
  logic                we_q, we_d;
  logic                store_q, store_d;
  logic                bank_q, bank_d;

  logic in_access;
  logic last;

  assign in_access = (state_q == ST_ACCESS);
  assign last      = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    waddr_d   = waddr_q;
    we_d      = we_q;
    store_d   = store_q;
    bank_d    = bank_q;
    stall_req = 1'b0;
    err_o     = 1'b0;
    we_o      = 1'b0;
    waddr_o   = '0;
    wdata_o   = '0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem_op(memrw_i)) begin
          stall_req = !rst;
          addr_d    = memaddr_i;
          sdata_d   = memdata_i;
          wdata_d   = wdata_i;
          waddr_d   = waddr_i;
          we_d      = we_i;
          store_d   = (memrw_i == MEM_STORE);
          bank_d    = (memaddr_i >= BANK_SPLIT);
          cnt_d     = '0;
          state_d   = ST_ACCESS;
        end else begin
          we_o    = we_i;
          waddr_o = waddr_i;
          wdata_o = wdata_i;
          err_o   = (memrw_i == MEM_RSVD) && !rst;
        end
      end
      ST_ACCESS: begin
        stall_req = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (last) begin
          if (!store_q) rdata_d = bank_q ? ram2_data_i : ram1_data_i;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // the stalled instruction is still on memrw_i here, so it must not be re-issued
        we_o    = we_q;
        waddr_o = waddr_q;
        wdata_o = store_q ? wdata_q : rdata_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      store_q <= 1'b0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      store_q <= store_d;
      bank_q  <= bank_d;
    end
  end

  sram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram1 (
    .sel_i      (in_access && !bank_q),
    .is_store_i (store_q),
    .last_i     (last),
    .addr_i     (addr_q),
    .wr_data_i  (sdata_q),
    .ce_o       (ram1_ce_o),
    .re_o       (ram1_re_o),
    .we_o       (ram1_we_o),
    .oe_o       (ram1_oe_o),
    .addr_o     (ram1_addr_o),
    .data_o     (ram1_data_o)
  );

  sram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram2 (
    .sel_i      (in_access && bank_q),
    .is_store_i (store_q),
    .last_i     (last),
    .addr_i     (addr_q),
    .wr_data_i  (sdata_q),
    .ce_o       (ram2_ce_o),
    .re_o       (ram2_re_o),
    .we_o       (ram2_we_o),
    .oe_o       (ram2_oe_o),
    .addr_o     (ram2_addr_o),
    .data_o     (ram2_data_o)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (WAIT_CYCLES 2 and 4), a timeline model checked every cycle,
// plus directed operations with hand-computed expectations.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        we_i      [2];
  logic [3:0]  waddr_i   [2];
  logic [15:0] wdata_i   [2];
  logic [15:0] memdata_i [2];
  logic [1:0]  memrw_i   [2];
  logic [15:0] memaddr_i [2];
  logic [15:0] r1_di     [2];
  logic [15:0] r2_di     [2];

  logic        o_we    [2];
  logic [3:0]  o_waddr [2];
  logic [15:0] o_wdata [2];
  logic        o_stall [2];
  logic        o_err   [2];
  logic [15:0] r1_do [2], r2_do [2];
  logic [15:0] r1_a  [2], r2_a  [2];
  logic        r1_oe [2], r2_oe [2];
  logic        r1_ce [2], r2_ce [2];
  logic        r1_re [2], r2_re [2];
  logic        r1_we [2], r2_we [2];

  int n_vec = 0;
  int n_err = 0;

  mem_ctrl #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .we_i(we_i[0]), .waddr_i(waddr_i[0]), .wdata_i(wdata_i[0]), .memdata_i(memdata_i[0]),
    .memrw_i(memrw_i[0]), .memaddr_i(memaddr_i[0]),
    .we_o(o_we[0]), .waddr_o(o_waddr[0]), .wdata_o(o_wdata[0]),
    .ram1_data_i(r1_di[0]), .ram1_data_o(r1_do[0]), .ram1_oe_o(r1_oe[0]), .ram1_addr_o(r1_a[0]),
    .ram1_ce_o(r1_ce[0]), .ram1_re_o(r1_re[0]), .ram1_we_o(r1_we[0]),
    .ram2_data_i(r2_di[0]), .ram2_data_o(r2_do[0]), .ram2_oe_o(r2_oe[0]), .ram2_addr_o(r2_a[0]),
    .ram2_ce_o(r2_ce[0]), .ram2_re_o(r2_re[0]), .ram2_we_o(r2_we[0]),
    .stall_req(o_stall[0]), .err_o(o_err[0])
  );

  mem_ctrl #(.WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .we_i(we_i[1]), .waddr_i(waddr_i[1]), .wdata_i(wdata_i[1]), .memdata_i(memdata_i[1]),
    .memrw_i(memrw_i[1]), .memaddr_i(memaddr_i[1]),
    .we_o(o_we[1]), .waddr_o(o_waddr[1]), .wdata_o(o_wdata[1]),
    .ram1_data_i(r1_di[1]), .ram1_data_o(r1_do[1]), .ram1_oe_o(r1_oe[1]), .ram1_addr_o(r1_a[1]),
    .ram1_ce_o(r1_ce[1]), .ram1_re_o(r1_re[1]), .ram1_we_o(r1_we[1]),
    .ram2_data_i(r2_di[1]), .ram2_data_o(r2_do[1]), .ram2_oe_o(r2_oe[1]), .ram2_addr_o(r2_a[1]),
    .ram2_ce_o(r2_ce[1]), .ram2_re_o(r2_re[1]), .ram2_we_o(r2_we[1]),
    .stall_req(o_stall[1]), .err_o(o_err[1])
  );

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic logic memop(input logic [1:0] rw);
    return (rw == 2'b01) || (rw == 2'b10);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [dut%0d]: got %0h, expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: t = position on the operation timeline (-1 idle, 1..W access cycles, W+1 result cycle).
  int          t       [2] = '{-1, -1};
  logic        m_store [2];
  logic        m_bank  [2];
  logic        m_we    [2];
  logic [3:0]  m_waddr [2];
  logic [15:0] m_addr  [2];
  logic [15:0] m_sdata [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rd    [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        t[k] <= -1;
      end else if (t[k] == -1) begin
        if (memop(memrw_i[k])) begin
          t[k]       <= 1;
          m_store[k] <= (memrw_i[k] == 2'b10);
          m_bank[k]  <= (memaddr_i[k] >= 16'h8000);
          m_we[k]    <= we_i[k];
          m_waddr[k] <= waddr_i[k];
          m_addr[k]  <= memaddr_i[k];
          m_sdata[k] <= memdata_i[k];
          m_wdata[k] <= wdata_i[k];
        end
      end else begin
        if (t[k] == wc(k)) m_rd[k] <= m_bank[k] ? r2_di[k] : r1_di[k];
        t[k] <= (t[k] == wc(k) + 1) ? -1 : t[k] + 1;
      end
    end
  end

  task automatic check_cycle(input int k);
    int          w;
    int          tt;
    logic        e_ce [2], e_re [2], e_we [2], e_oe [2];
    logic [15:0] e_a  [2], e_d  [2];
    logic        e_stall, e_err;
    w  = wc(k);
    tt = t[k];
    for (int b = 0; b < 2; b++) begin
      e_ce[b] = 1'b1; e_re[b] = 1'b1; e_we[b] = 1'b1; e_oe[b] = 1'b0;
      e_a[b] = 16'h0; e_d[b] = 16'h0;
    end
    if (tt >= 1 && tt <= w) begin
      int b;
      b = m_bank[k] ? 1 : 0;
      e_ce[b] = 1'b0;
      e_a[b]  = m_addr[k];
      if (m_store[k]) begin
        e_oe[b] = 1'b1;
        e_d[b]  = m_sdata[k];
        e_we[b] = (tt == w);
      end else begin
        e_re[b] = 1'b0;
      end
    end
    e_stall = (tt == -1) ? memop(memrw_i[k]) : (tt <= w);
    e_err   = (tt == -1) && (memrw_i[k] == 2'b11);
    chk("stall_req", k, o_stall[k], e_stall);
    chk("err_o", k, o_err[k], e_err);
    chk("ram1_ce", k, r1_ce[k], e_ce[0]);
    chk("ram1_re", k, r1_re[k], e_re[0]);
    chk("ram1_we", k, r1_we[k], e_we[0]);
    chk("ram1_oe", k, r1_oe[k], e_oe[0]);
    chk("ram1_addr", k, r1_a[k], e_a[0]);
    chk("ram1_data", k, r1_do[k], e_d[0]);
    chk("ram2_ce", k, r2_ce[k], e_ce[1]);
    chk("ram2_re", k, r2_re[k], e_re[1]);
    chk("ram2_we", k, r2_we[k], e_we[1]);
    chk("ram2_oe", k, r2_oe[k], e_oe[1]);
    chk("ram2_addr", k, r2_a[k], e_a[1]);
    chk("ram2_data", k, r2_do[k], e_d[1]);
    if (tt == -1 && !memop(memrw_i[k])) begin
      chk("pt_we_o", k, o_we[k], we_i[k]);
      chk("pt_waddr_o", k, o_waddr[k], waddr_i[k]);
      chk("pt_wdata_o", k, o_wdata[k], wdata_i[k]);
    end else if (tt == w + 1) begin
      chk("wb_we_o", k, o_we[k], m_we[k]);
      chk("wb_waddr_o", k, o_waddr[k], m_waddr[k]);
      chk("wb_wdata_o", k, o_wdata[k], m_store[k] ? m_wdata[k] : m_rd[k]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) check_cycle(k);
    end
  end

  int          n_stall, n_ce1, n_re1, n_we1, n_oe1, n_ce2, n_re2, n_we2, n_oe2;
  logic [15:0] seen_a2, seen_d2;

  task automatic set_in(input int k, input logic [1:0] op, input logic [15:0] addr,
                        input logic [15:0] sdata, input logic wen, input logic [3:0] wa,
                        input logic [15:0] wd);
    memrw_i[k]   = op;
    memaddr_i[k] = addr;
    memdata_i[k] = sdata;
    we_i[k]      = wen;
    waddr_i[k]   = wa;
    wdata_i[k]   = wd;
  endtask

  // Presents an op from an IDLE cycle and steps until stall_req drops; returns in the result cycle.
  task automatic do_op(input int k, input logic [1:0] op, input logic [15:0] addr,
                       input logic [15:0] sdata, input logic wen, input logic [3:0] wa,
                       input logic [15:0] wd);
    int cyc;
    set_in(k, op, addr, sdata, wen, wa, wd);
    #1;
    cyc = 0;
    n_stall = 0; n_ce1 = 0; n_re1 = 0; n_we1 = 0; n_oe1 = 0;
    n_ce2 = 0; n_re2 = 0; n_we2 = 0; n_oe2 = 0;
    seen_a2 = 16'h0; seen_d2 = 16'h0;
    while (o_stall[k] && cyc < 40) begin
      n_stall++;
      if (!r1_ce[k]) n_ce1++;
      if (!r1_re[k]) n_re1++;
      if (!r1_we[k]) n_we1++;
      if (r1_oe[k])  n_oe1++;
      if (!r2_ce[k]) begin n_ce2++; seen_a2 = r2_a[k]; seen_d2 = r2_do[k]; end
      if (!r2_re[k]) n_re2++;
      if (!r2_we[k]) n_we2++;
      if (r2_oe[k])  n_oe2++;
      cyc++;
      @(posedge clk); #1;
    end
    if (cyc >= 40) chk("stall_timeout", k, 32'(cyc), 32'd0);
  endtask

  task automatic next_idle(input int k);
    @(posedge clk); #1;
    memrw_i[k] = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_in(k, 2'b00, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
      r1_di[k] = 16'h0;
      r2_di[k] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_stall", 0, o_stall[0], 1'b0);
    chk("reset_err", 0, o_err[0], 1'b0);
    chk("reset_strobes", 1, {r1_ce[1], r1_re[1], r1_we[1], r2_ce[1], r2_re[1], r2_we[1]}, 6'b111111);
    chk("reset_oe", 1, {r1_oe[1], r2_oe[1]}, 2'b00);
    chk("reset_addr", 0, {r1_a[0], r2_a[0]}, 32'h0);

    // Pass-through
    @(posedge clk); #1;
    set_in(0, 2'b00, 16'h0000, 16'h0000, 1'b1, 4'd3, 16'h1234);
    #1;
    chk("pt_lit_we", 0, o_we[0], 1'b1);
    chk("pt_lit_waddr", 0, o_waddr[0], 4'd3);
    chk("pt_lit_wdata", 0, o_wdata[0], 16'h1234);
    chk("pt_lit_stall", 0, o_stall[0], 1'b0);
    chk("pt_lit_strobes", 0, {r1_ce[0], r1_re[0], r1_we[0], r2_ce[0], r2_re[0], r2_we[0]}, 6'b111111);

    // Load from ram1, W=2
    @(posedge clk); #1;
    r1_di[0] = 16'hBEEF;
    r2_di[0] = 16'hDEAD;
    do_op(0, 2'b01, 16'h0010, 16'h0000, 1'b1, 4'd7, 16'h1111);
    chk("ld1_stall_cycles", 0, 32'(n_stall), 32'd3);
    chk("ld1_ce1_cycles", 0, 32'(n_ce1), 32'd2);
    chk("ld1_re1_cycles", 0, 32'(n_re1), 32'd2);
    chk("ld1_ram2_active", 0, 32'(n_ce2 + n_re2 + n_we2 + n_oe2), 32'd0);
    chk("ld1_wdata", 0, o_wdata[0], 16'hBEEF);
    chk("ld1_waddr", 0, o_waddr[0], 4'd7);
    chk("ld1_we", 0, o_we[0], 1'b1);
    chk("ld1_done_stall", 0, o_stall[0], 1'b0);

    // Store to ram2, W=2
    next_idle(0);
    do_op(0, 2'b10, 16'h8004, 16'h55AA, 1'b0, 4'd2, 16'h2222);
    chk("st2_stall_cycles", 0, 32'(n_stall), 32'd3);
    chk("st2_ce2_cycles", 0, 32'(n_ce2), 32'd2);
    chk("st2_we2_low", 0, 32'(n_we2), 32'd1);
    chk("st2_oe2_cycles", 0, 32'(n_oe2), 32'd2);
    chk("st2_addr", 0, seen_a2, 16'h8004);
    chk("st2_data", 0, seen_d2, 16'h55AA);
    chk("st2_ram1_active", 0, 32'(n_ce1 + n_re1 + n_we1 + n_oe1), 32'd0);
    chk("st2_wdata", 0, o_wdata[0], 16'h2222);
    chk("st2_we", 0, o_we[0], 1'b0);
    next_idle(0);

    // Reserved code
    set_in(0, 2'b11, 16'h8000, 16'h0000, 1'b1, 4'd9, 16'hABCD);
    #1;
    chk("rsvd_err", 0, o_err[0], 1'b1);
    chk("rsvd_stall", 0, o_stall[0], 1'b0);
    chk("rsvd_wdata", 0, o_wdata[0], 16'hABCD);
    chk("rsvd_waddr", 0, o_waddr[0], 4'd9);
    chk("rsvd_strobes", 0, {r1_ce[0], r1_re[0], r1_we[0], r2_ce[0], r2_re[0], r2_we[0]}, 6'b111111);
    next_idle(0);
    #1;
    chk("rsvd_err_pulse", 0, o_err[0], 1'b0);

    // Back-to-back load then store, W=4
    r1_di[1] = 16'hCAFE;
    r2_di[1] = 16'h0BAD;
    do_op(1, 2'b01, 16'h0020, 16'h0000, 1'b1, 4'd5, 16'h3333);
    chk("bb_ld_stall_cycles", 1, 32'(n_stall), 32'd5);
    chk("bb_ld_ce1_cycles", 1, 32'(n_ce1), 32'd4);
    chk("bb_ld_wdata", 1, o_wdata[1], 16'hCAFE);
    chk("bb_gap_stall", 1, o_stall[1], 1'b0);
    @(posedge clk); #1;
    do_op(1, 2'b10, 16'h9000, 16'h0F0F, 1'b0, 4'd6, 16'h4444);
    chk("bb_st_stall_cycles", 1, 32'(n_stall), 32'd5);
    chk("bb_st_ce2_cycles", 1, 32'(n_ce2), 32'd4);
    chk("bb_st_we2_low", 1, 32'(n_we2), 32'd3);
    chk("bb_st_data", 1, seen_d2, 16'h0F0F);
    chk("bb_st_ram1_active", 1, 32'(n_ce1), 32'd0);
    next_idle(1);
    #1;
    chk("bb_no_reissue", 1, o_stall[1], 1'b0);

    // Reset on the second access cycle of a store, W=4
    @(posedge clk); #1;
    set_in(1, 2'b10, 16'h0100, 16'h1357, 1'b1, 4'd1, 16'h5555);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rm_we1_mid", 1, r1_we[1], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    memrw_i[1] = 2'b00;
    #1;
    chk("rm_strobes", 1, {r1_ce[1], r1_re[1], r1_we[1], r2_ce[1], r2_re[1], r2_we[1]}, 6'b111111);
    chk("rm_oe", 1, r1_oe[1], 1'b0);
    chk("rm_stall", 1, o_stall[1], 1'b0);
    chk("rm_addr", 1, r1_a[1], 16'h0000);
    @(posedge clk); #1;
    r2_di[1] = 16'h7777;
    do_op(1, 2'b01, 16'hA000, 16'h0000, 1'b1, 4'd4, 16'h6666);
    chk("rm_ld_stall_cycles", 1, 32'(n_stall), 32'd5);
    chk("rm_ld_wdata", 1, o_wdata[1], 16'h7777);
    chk("rm_ld_waddr", 1, o_waddr[1], 4'd4);
    next_idle(1);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete, %0d miscompares so far", n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Parametrised, multi-cycle successor to the MEM stage of the 16-bit pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Routes each load/store to one of two external SRAM banks (ram1/ram2) by address, and sequences configurable wait-state accesses.
- Holds the pipeline with stall_req until data is valid; non-memory instructions pass through with zero latency.

Parameters:
DATA_W, 16, data bus and register-write data width
ADDR_W, 16, memory address width
REG_W, 4, register-file write-address width
WAIT_CYCLES, 2, SRAM access cycles per transfer; legal range 2..15
BANK_SPLIT, 16'h8000, addresses >= BANK_SPLIT go to ram2, addresses below go to ram1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
we_i  in  1  register write enable from EX/MEM
waddr_i  in  REG_W  destination register
wdata_i  in  DATA_W  ALU result / pass-through write data
memdata_i  in  DATA_W  store data
memrw_i  in  2  00 none, 01 load, 10 store, 11 reserved
memaddr_i  in  ADDR_W  load/store address
we_o  out  1  register write enable to MEM/WB
waddr_o  out  REG_W  destination register to MEM/WB
wdata_o  out  DATA_W  write-back data to MEM/WB
ramN_data_i  in  DATA_W  bank N read data (N=1,2)
ramN_data_o  out  DATA_W  bank N write data
ramN_oe_o  out  1  bank N data-bus drive enable, 1 = drive
ramN_addr_o  out  ADDR_W  bank N address
ramN_ce_o, ramN_re_o, ramN_we_o  out  1 each  bank N strobes, active-low
stall_req  out  1  stall request to hazard unit
err_o  out  1  one-cycle pulse on a reserved memrw_i code

Behaviour:
- **Reset** (any cycle, including mid-access):
  - state=IDLE, counter=0.
  - All ce/re/we = 1, oe = 0, addr/data_o = 0, stall_req = 0, err_o = 0.
  - An in-flight store is abandoned; a partial write is accepted.
- **States:** IDLE, ACCESS, DONE.
- **IDLE, memrw_i=00:**
  - we_o/waddr_o/wdata_o = we_i/waddr_i/wdata_i, combinationally.
  - stall_req = 0.
- **IDLE, memrw_i=11:**
  - Treated as 00 (pass-through), with err_o = 1 for that cycle.
- **IDLE, memrw_i=01 or 10:**
  - stall_req = 1 combinationally in the same cycle.
  - Latch addr, store data, we_i, waddr_i, the op and the bank select (memaddr_i >= BANK_SPLIT selects ram2).
  - counter = 0; next state is ACCESS.
- **ACCESS:**
  - Selected bank: ce = 0, addr = latched address.
  - Load: re = 0.
  - Store: oe = 1, data_o = latched data, we = 0 while counter < WAIT_CYCLES-1, we = 1 on the final cycle (data hold).
  - Unselected bank: all strobes 1, oe = 0.
  - stall_req = 1; counter increments each cycle.
  - On the cycle counter = WAIT_CYCLES-1: a load captures ramN_data_i into the read register; next state is DONE.
- **DONE:**
  - stall_req = 0; all strobes released.
  - we_o/waddr_o = latched values.
  - wdata_o = captured read data for a load, the latched wdata_i for a store.
  - memrw_i is ignored this cycle (the same instruction is still presented); next state is IDLE.
- **Latency:**
  - Memory op: stall_req is high for WAIT_CYCLES+1 consecutive cycles.
  - Results are valid on the MEM/WB inputs in the DONE cycle; total WAIT_CYCLES+2 cycles from request to advance.
- **Back-to-back ops:** a new request is accepted in the IDLE cycle after DONE. No request is ever lost, and none is issued twice.
- Inputs may change during ACCESS; only latched values are used.
- Only one bank is active per access; both banks are never active simultaneously.

Decomposition:
- **Shared package** `mem_defs`:
  - memrw encodings: MEM_NONE=2'b00, MEM_LOAD=2'b01, MEM_STORE=2'b10, MEM_RSVD=2'b11.
  - FSM state encodings.
  - Default BANK_SPLIT.
- **Sub-module** `sram_port`: one instance per bank. Takes sel/op/phase and drives the strobes, addr, data_o and oe for a single bank.
- The FSM, latches and write-back mux stay in mem_ctrl.

Test Plan:
- **Pass-through:** memrw_i=00, we_i=1, waddr_i=3, wdata_i=16'h1234 → same-cycle we_o=1, waddr_o=3, wdata_o=16'h1234, stall_req=0, all strobes 1.
- **Load from ram1** (WAIT_CYCLES=2): addr 16'h0010, ram1_data_i=16'hBEEF → stall_req high for 3 cycles; ram1_ce/re low for 2 cycles; DONE shows wdata_o=16'hBEEF, waddr_o latched; ram2 idle throughout.
- **Store to ram2:** addr 16'h8004, memdata_i=16'h55AA → ram2_addr_o=16'h8004, ram2_data_o=16'h55AA, oe=1; ram2_we low for 1 cycle then high for 1 cycle; ram1 untouched; stall_req high for 3 cycles.
- **Back-to-back and wait states:** load then store, with WAIT_CYCLES=4 → exactly one ACCESS sequence per op; stall_req high for 5 cycles each, with one low DONE cycle between them.
- **Reset mid-access:** rst=1 on the 2nd ACCESS cycle → next cycle all strobes 1, oe=0, stall_req=0, state IDLE; the next request is served normally.
- **Reserved code:** memrw_i=11 → err_o one-cycle pulse, pass-through outputs, no strobes asserted, stall_req=0.
